// File: rtl/mac_pkg.sv
// Shared helpers for the pipelined MAC: sizing, lane slicing and saturating add.
package mac_pkg;

    // Widest accumulator the saturating adder supports.
    localparam int MAXW = 64;

    typedef struct packed {
        logic [MAXW-1:0] sum;
        logic            sat;
    } sat_res_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Exact width of a full-beat dot product.
    function automatic int pw_of(input int dw, input int lanes);
        return 2 * dw + clog2(lanes);
    endfunction

    // MSB of lane `lane` in a packed vector; lane 0 sits in the top bits.
    function automatic int lane_msb(input int lane, input int lanes, input int w);
        return (lanes - lane) * w - 1;
    endfunction

    // Add two width-w values (already extended to MAXW+1 bits in their own
    // signedness) and clamp the result into the width-w range.
    function automatic sat_res_t sat_add(input logic signed [MAXW:0] a,
                                         input logic signed [MAXW:0] b,
                                         input int w,
                                         input logic sgn);
        logic signed [MAXW+1:0] s;
        logic signed [MAXW+1:0] hi;
        logic signed [MAXW+1:0] lo;
        logic signed [MAXW+1:0] one;
        sat_res_t r;
        one    = '0;
        one[0] = 1'b1;
        s      = {a[MAXW], a} + {b[MAXW], b};
        hi     = (one <<< (sgn ? w - 1 : w)) - one;
        lo     = sgn ? -(one <<< (w - 1)) : '0;
        r.sat  = 1'b1;
        if (s > hi) begin
            r.sum = hi[MAXW-1:0];
        end else if (s < lo) begin
            r.sum = lo[MAXW-1:0];
        end else begin
            r.sum = s[MAXW-1:0];
            r.sat = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_adder_tree.sv
// Combinational binary reduction of LANES products into one full-precision sum.
module mac_adder_tree
    import mac_pkg::*;
#(
    parameter int LANES  = 16,
    parameter int IW     = 16,
    parameter int SIGNED = 0
) (
    input  logic [LANES*IW-1:0]           prod_i,
    output logic [IW+clog2(LANES)-1:0]    sum_o
);

    localparam int LV = clog2(LANES);
    localparam int OW = IW + LV;

    // Level 0 holds the extended products; each later level halves the node count.
    // Every node carries the final width so no level can overflow.
    for (genvar l = 0; l <= LV; l++) begin : g_lvl
        localparam int N = LANES >> l;
        logic [OW-1:0] node [N];
        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < N; i++) begin : g_in
                localparam int M = lane_msb(i, LANES, IW);
                assign node[i] = {{(OW-IW){(SIGNED != 0) && prod_i[M]}}, prod_i[M -: IW]};
            end
        end else begin : g_add
            for (genvar j = 0; j < N; j++) begin : g_node
                assign node[j] = g_lvl[l-1].node[2*j] + g_lvl[l-1].node[2*j+1];
            end
        end
    end

    assign sum_o = g_lvl[LV].node[0];

endmodule

// File: rtl/mac_acc_pipe.sv
// Four-stage multiply / adder-tree / saturating-accumulate pipeline with a
// global stall driven by the result handshake.
module mac_acc_pipe
    import mac_pkg::*;
#(
    parameter int LANES  = 16,
    parameter int DW     = 8,
    parameter int ACC_W  = 32,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [LANES*DW-1:0]   pixels_in,
    input  logic [LANES*DW-1:0]   weights_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      sum_out,
    output logic                  overflow
);

    localparam int PW  = pw_of(DW, LANES);
    localparam int PRW = 2 * DW;

    logic                   en;
    logic                   vld_a_q, last_a_q;
    logic [LANES*DW-1:0]    pix_a_q, wgt_a_q;
    logic                   vld_b_q, last_b_q;
    logic [LANES*PRW-1:0]   prod_b_d, prod_b_q;
    logic                   vld_c_q, last_c_q;
    logic [PW-1:0]          tree_c_d, tree_c_q;
    logic [ACC_W-1:0]       acc_d, acc_q, sum_d, sum_q;
    logic                   sticky_d, sticky_q, ovf_d, ovf_q, out_vld_d, out_vld_q;
    logic signed [MAXW:0]   acc_x, tree_x;
    sat_res_t               sat_r;

    // A held result freezes the whole pipe; nothing advances until it is taken.
    assign en        = !(out_vld_q && !out_ready);
    assign in_ready  = en && !rst;
    assign out_valid = out_vld_q;
    assign sum_out   = sum_q;
    assign overflow  = ovf_q;

    // Stage A: capture the incoming beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_a_q  <= 1'b0;
            last_a_q <= 1'b0;
            pix_a_q  <= '0;
            wgt_a_q  <= '0;
        end else if (en) begin
            vld_a_q  <= in_valid;
            last_a_q <= in_last;
            pix_a_q  <= pixels_in;
            wgt_a_q  <= weights_in;
        end
    end

    // Per-lane products; operands are extended to full product width first so a
    // plain multiply yields the correct low bits for either signedness.
    always_comb begin
        prod_b_d = '0;
        for (int i = 0; i < LANES; i++) begin
            logic [DW-1:0] p, w;
            p = pix_a_q[lane_msb(i, LANES, DW) -: DW];
            w = wgt_a_q[lane_msb(i, LANES, DW) -: DW];
            prod_b_d[lane_msb(i, LANES, PRW) -: PRW] =
                {{DW{(SIGNED != 0) && p[DW-1]}}, p} * {{DW{(SIGNED != 0) && w[DW-1]}}, w};
        end
    end

    // Stage B: register the products.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_b_q  <= 1'b0;
            last_b_q <= 1'b0;
            prod_b_q <= '0;
        end else if (en) begin
            vld_b_q  <= vld_a_q;
            last_b_q <= last_a_q;
            prod_b_q <= prod_b_d;
        end
    end

    mac_adder_tree #(
        .LANES  (LANES),
        .IW     (PRW),
        .SIGNED (SIGNED)
    ) u_tree (
        .prod_i (prod_b_q),
        .sum_o  (tree_c_d)
    );

    // Stage C: register the reduced beat sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_c_q  <= 1'b0;
            last_c_q <= 1'b0;
            tree_c_q <= '0;
        end else if (en) begin
            vld_c_q  <= vld_b_q;
            last_c_q <= last_b_q;
            tree_c_q <= tree_c_d;
        end
    end

    // Accumulate with saturation; a group's last beat retires to the output and
    // clears the accumulator so the next group can follow without a gap.
    always_comb begin
        acc_d     = acc_q;
        sticky_d  = sticky_q;
        sum_d     = sum_q;
        ovf_d     = ovf_q;
        out_vld_d = out_vld_q;
        acc_x     = {{(MAXW+1-ACC_W){(SIGNED != 0) && acc_q[ACC_W-1]}}, acc_q};
        tree_x    = {{(MAXW+1-PW){(SIGNED != 0) && tree_c_q[PW-1]}}, tree_c_q};
        sat_r     = sat_add(acc_x, tree_x, ACC_W, SIGNED != 0);
        if (en) begin
            // With en high a valid result is being accepted this edge.
            out_vld_d = 1'b0;
            if (vld_c_q) begin
                if (last_c_q) begin
                    sum_d     = sat_r.sum[ACC_W-1:0];
                    ovf_d     = sticky_q | sat_r.sat;
                    out_vld_d = 1'b1;
                    acc_d     = '0;
                    sticky_d  = 1'b0;
                end else begin
                    acc_d    = sat_r.sum[ACC_W-1:0];
                    sticky_d = sticky_q | sat_r.sat;
                end
            end
        end
    end

    // Stage D: accumulator, sticky flag and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            sticky_q  <= 1'b0;
            sum_q     <= '0;
            ovf_q     <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            sticky_q  <= sticky_d;
            sum_q     <= sum_d;
            ovf_q     <= ovf_d;
            out_vld_q <= out_vld_d;
        end
    end

endmodule

// File: tb/tb_mac_acc_pipe.sv
// Bench for mac_acc_pipe: three configurations share one stimulus stream and
// are checked against a group-level dot-product/clamp model.
module tb_mac_acc_pipe;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_last, out_ready;
    logic [127:0] pixels_in, weights_in;
    logic rdy0, rdy1, rdy2, ov0, ov1, ov2, of0, of1, of2;
    logic [31:0] s0;
    logic [19:0] s1, s2;

    always #5 clk = ~clk;

    mac_acc_pipe u_d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_last(in_last),
        .pixels_in(pixels_in), .weights_in(weights_in), .out_valid(ov0),
        .out_ready(out_ready), .sum_out(s0), .overflow(of0));

    mac_acc_pipe #(.ACC_W(20)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_last(in_last),
        .pixels_in(pixels_in), .weights_in(weights_in), .out_valid(ov1),
        .out_ready(out_ready), .sum_out(s1), .overflow(of1));

    mac_acc_pipe #(.ACC_W(20), .SIGNED(1)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_last(in_last),
        .pixels_in(pixels_in), .weights_in(weights_in), .out_valid(ov2),
        .out_ready(out_ready), .sum_out(s2), .overflow(of2));

    typedef struct {
        longint s0, s1, s2;
        bit     o0, o1, o2;
    } res_t;

    res_t   exp_q[$];
    longint acc0 = 0, acc1 = 0, acc2 = 0;
    bit     st0 = 0, st1 = 0, st2 = 0;
    int     n_chk = 0, n_fail = 0;
    bit     rnd_on = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint clampf(input longint v, input longint lo, input longint hi,
                                      output bit sat);
        sat = 1'b1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        sat = 1'b0;
        return v;
    endfunction

    // Reference model: per accepted beat, dot product then clamped accumulation.
    always @(posedge clk or posedge rst) begin
        longint du, ds;
        bit     sat;
        logic [7:0] p, w;
        if (rst) begin
            exp_q.delete();
            acc0 = 0; acc1 = 0; acc2 = 0;
            st0 = 0; st1 = 0; st2 = 0;
        end else if (in_valid && rdy0) begin
            du = 0;
            ds = 0;
            for (int i = 0; i < 16; i++) begin
                p = pixels_in[(16-i)*8-1 -: 8];
                w = weights_in[(16-i)*8-1 -: 8];
                du += longint'(p) * longint'(w);
                ds += longint'($signed(p)) * longint'($signed(w));
            end
            acc0 = clampf(acc0 + du, 0, (longint'(1) << 32) - 1, sat); st0 |= sat;
            acc1 = clampf(acc1 + du, 0, (longint'(1) << 20) - 1, sat); st1 |= sat;
            acc2 = clampf(acc2 + ds, -(longint'(1) << 19), (longint'(1) << 19) - 1, sat); st2 |= sat;
            if (in_last) begin
                exp_q.push_back('{acc0, acc1, acc2, st0, st1, st2});
                acc0 = 0; acc1 = 0; acc2 = 0;
                st0 = 0; st1 = 0; st2 = 0;
            end
        end
    end

    // Output checker: every cycle a result is presented it must match the model head.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_in_ready", {rdy0, rdy1, rdy2}, 0);
            chk("rst_out_valid", {ov0, ov1, ov2}, 0);
            chk("rst_overflow", {of0, of1, of2}, 0);
            chk("rst_sum", (|s0) | (|s1) | (|s2), 0);
        end else if (ov0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", ov0, 0);
            end else begin
                chk("d0_sum", s0, exp_q[0].s0);
                chk("d0_ovf", of0, exp_q[0].o0);
                chk("d1_valid", ov1, 1);
                chk("d1_sum", s1, exp_q[0].s1);
                chk("d1_ovf", of1, exp_q[0].o1);
                chk("d2_valid", ov2, 1);
                chk("d2_sum", longint'($signed(s2)), exp_q[0].s2);
                chk("d2_ovf", of2, exp_q[0].o2);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic beat_raw(input logic [127:0] p, input logic [127:0] w, input bit last);
        bit ok;
        int n;
        in_valid   = 1'b1;
        pixels_in  = p;
        weights_in = w;
        in_last    = last;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = rdy0;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) chk("accept_timeout", rdy0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic beat(input logic [7:0] p, input logic [7:0] w, input bit last);
        beat_raw({16{p}}, {16{w}}, last);
    endtask

    task automatic wait_valid(input string nm);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = ov0;
        end
        if (!got) chk({nm, "_timeout"}, ov0, 1);
    endtask

    task automatic realign();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt, len, idle;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        pixels_in = '0; weights_in = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", rdy0, 1);
        realign();

        // Single full-scale beat and its four-edge latency.
        beat(8'hFF, 8'hFF, 1'b1);
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            chk("latency_valid", ov0, (e == 4));
        end
        chk("t1_sum", s0, 1040400);
        chk("t1_ovf", of0, 0);
        realign();

        // Four-beat group, one result only.
        for (int b = 0; b < 4; b++) beat(8'd1, 8'd2, b == 3);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (ov0) begin
                cnt++;
                chk("t2_sum", s0, 128);
            end
        end
        chk("t2_count", cnt, 1);
        realign();

        // Backpressure across two groups.
        out_ready = 1'b0;
        fork
            begin
                beat(8'd1, 8'd1, 1'b0);
                beat(8'd1, 8'd1, 1'b1);
                beat(8'd2, 8'd1, 1'b0);
                beat(8'd2, 8'd1, 1'b1);
            end
        join_none
        repeat (12) @(negedge clk);
        chk("t3_stall_ready", rdy0, 0);
        chk("t3_hold_valid", ov0, 1);
        chk("t3_hold_sum", s0, 32);
        wait fork;
        realign();
        out_ready = 1'b1;
        @(posedge clk);
        wait_valid("t3");
        chk("t3_second_sum", s0, 64);
        realign();

        // Unsigned saturation on the 20-bit instance, then sticky flag cleared.
        beat(8'hFF, 8'hFF, 1'b0);
        beat(8'hFF, 8'hFF, 1'b1);
        wait_valid("t4a");
        chk("t4_sat_sum", s1, 1048575);
        chk("t4_sat_ovf", of1, 1);
        chk("t4_wide_sum", s0, 2080800);
        realign();
        beat(8'd1, 8'd1, 1'b1);
        wait_valid("t4b");
        chk("t4_after_sum", s1, 16);
        chk("t4_after_ovf", of1, 0);
        realign();

        // Signed arithmetic and signed positive saturation.
        beat(8'h80, 8'h7F, 1'b1);
        wait_valid("t5a");
        chk("t5_neg_sum", longint'($signed(s2)), -260096);
        chk("t5_neg_ovf", of2, 0);
        chk("t5_unsigned_sum", s0, 260096);
        realign();
        beat(8'h80, 8'h80, 1'b0);
        beat(8'h80, 8'h80, 1'b1);
        wait_valid("t5b");
        chk("t5_sat_sum", longint'($signed(s2)), 524287);
        chk("t5_sat_ovf", of2, 1);
        realign();

        // Asynchronous reset with a held result and a partial group in flight.
        out_ready = 1'b0;
        beat(8'd1, 8'd1, 1'b1);
        beat(8'd3, 8'd3, 1'b0);
        beat(8'd3, 8'd3, 1'b0);
        wait_valid("t6a");
        chk("t6_held_sum", s0, 16);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_valid", ov0, 0);
        chk("t6_async_sum", s0, 0);
        chk("t6_async_ready", rdy0, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        realign();
        beat(8'd1, 8'd3, 1'b1);
        wait_valid("t6b");
        chk("t6_fresh_sum", s0, 48);
        chk("t6_fresh_ovf", of0, 0);
        realign();

        // Randomised groups, bubbles and backpressure.
        rnd_on = 1'b1;
        fork
            while (rnd_on) begin
                @(posedge clk);
                #1;
                if (rnd_on) out_ready = ($urandom_range(0, 3) != 0);
            end
        join_none
        for (int g = 0; g < 40; g++) begin
            len = $urandom_range(1, 5);
            for (int b = 0; b < len; b++) begin
                idle = $urandom_range(0, 2);
                repeat (idle) realign();
                beat_raw({$urandom, $urandom, $urandom, $urandom},
                         {$urandom, $urandom, $urandom, $urandom}, b == len - 1);
            end
        end
        rnd_on = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_acc_pipe.md
Name: mac_acc_pipe

Overview:
- Parametrised, pipelined successor to the 16-lane 8-bit multiply/adder-tree MAC.
- Multiplies LANES pixel/weight pairs per beat, reduces them through an adder tree, and accumulates across a multi-beat group (kernels larger than one beat).
- Result is presented on a valid/ready output with a saturation flag.
- Sits between the pixel/weight fetch stage and the convolution result writeback.

Parameters:
LANES, 16, number of pixel/weight pairs per beat; power of 2, range 2..64
DW, 8, bit width of each pixel and each weight
ACC_W, 32, accumulator and output width; must be >= PW = 2*DW + clog2(LANES)
SIGNED, 0, 0 = unsigned operands and arithmetic; 1 = two's-complement operands and arithmetic

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  beat present on pixels_in/weights_in/in_last
in_ready  output  1  block can accept a beat this cycle
in_last  input  1  beat is the final beat of an accumulation group
pixels_in  input  LANES*DW  lane i occupies bits [(LANES-i)*DW-1 -: DW]; lane 0 is the MSBs
weights_in  input  LANES*DW  same lane packing as pixels_in
out_valid  output  1  sum_out/overflow hold a completed group result
out_ready  input  1  downstream accepts the result
sum_out  output  ACC_W  accumulated group result
overflow  output  1  saturation occurred somewhere in the group

Behaviour:
- Reset (asynchronous, any time including mid-group):
  - in_ready=0 while rst is high; in_ready=1 on the first cycle after release.
  - out_valid=0, sum_out=0, overflow=0.
  - All stage valids, the accumulator and the sticky overflow are cleared; any partial group is discarded.
- Global stall: en = !(out_valid && !out_ready); in_ready = en. When en=0, every stage register holds its value.
- Accept: a beat is taken on a rising edge with in_valid && in_ready.
- Stage A: register pixels, weights, in_last and valid.
- Stage B: LANES products of width 2*DW (signed or unsigned per SIGNED), registered.
- Stage C:
  - Combinational adder tree with log2(LANES) levels.
  - Each level widens by 1 bit; the result is PW bits, registered.
  - Sign-extend the tree result when SIGNED=1, zero-extend otherwise.
- Stage D (accumulate), when valid_c && en:
  - nxt = sat(acc + tree).
  - If nxt saturated, set sticky_ovf.
  - If last_c=0: acc <= nxt.
  - If last_c=1: sum_out <= nxt; overflow <= sticky_ovf | this-beat saturation; out_valid <= 1; acc <= 0; sticky_ovf <= 0.
- Saturation limits:
  - Unsigned: clamp to 2^ACC_W-1.
  - Signed: clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
- Output handshake:
  - out_valid clears on out_valid && out_ready unless a new result loads on the same edge, in which case it stays 1 with the new data.
  - sum_out and overflow are stable while out_valid && !out_ready.
- Latency: counting the accepting edge as edge 1, out_valid rises after edge 4 for a group's last beat, assuming no stall. Throughput is 1 beat/cycle with no bubbles.
- A single-beat group (in_last=1 on its first beat) is legal.
- Back-to-back groups: the accumulator is already cleared for the next beat, so there is no gap between groups.
- Beats with in_valid=0 insert bubbles and do not affect acc.

Decomposition:
- Package mac_pkg:
  - clog2 function.
  - PW derivation function: 2*DW + clog2(LANES).
  - Saturating-add function parametrised by width and signedness.
  - Lane-slice index helper.
- Sub-module mac_adder_tree: purely combinational, parametrised (LANES, IW, SIGNED), built as a generate-based binary reduction tree.
- The top level owns all registers, the handshake and the accumulator.

Test Plan:
- Unsigned single beat, defaults: all pixels=255, weights=255, in_last=1 -> after 4 edges out_valid=1, sum_out=1040400, overflow=0.
- Group of 4 beats: pixels=1, weights=2, in_last on beat 4, back-to-back -> one result sum_out=128; out_valid asserted exactly once.
- Backpressure: out_ready=0 while two groups (sums 32 and 64) stream in -> in_ready drops, the first result holds at 32 until out_ready=1, then 64 follows; no beat lost or duplicated.
- Unsigned saturation, ACC_W=20: two beats of all-255 operands -> sum_out=1048575, overflow=1; the next group of pixels=1, weights=1 gives sum_out=16, overflow=0 (sticky flag cleared).
- SIGNED=1 single beat: pixels=-128, weights=127 -> sum_out=-260096; then pixels=-128, weights=-128 with ACC_W=20 over 2 beats -> saturates to 524287, overflow=1.
- Reset mid-group: 2 of 3 beats accepted, rst pulsed asynchronously between edges -> outputs 0 immediately; a fresh single beat of pixels=1, weights=3 yields sum_out=48, with no residue from the aborted group.
